// File: rtl/wl_pulse_ctrl.sv
// wl_pulse_ctrl: drives one word line for PULSE_W cycles per access, then
// precharges for PRE_W cycles before the next access can start.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is a pure decode of the state (IDLE, not in reset). It never
// depends on in_valid. The producer may change or drop word/in_valid at any
// time, and nothing is latched unless both are high.
module wl_pulse_ctrl #(
    parameter int PULSE_W = 4,
    parameter int PRE_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  wl_out,
    output logic        pre_en,
    output logic        done,
    output logic        err,
    output logic        err_sticky,
    input  logic        err_clr,
    output logic [15:0] acc_cnt,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PRECH  = 2'd2
    } state_t;

    // Counter reload values: the counter counts down to zero, so load N-1.
    localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
    localparam logic [3:0] PRE_LD   = 4'(PRE_W - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  wl_q, wl_d;
    logic        pre_q, pre_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        sticky_q, sticky_d;
    logic [15:0] acc_q, acc_d;

    logic        accept;
    logic        word_legal;

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
    assign word_legal = (word != 8'h00) && ((word & (word - 8'h01)) == 8'h00);
    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept     = in_valid && in_ready;

    assign wl_out     = wl_q;
    assign pre_en     = pre_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign acc_cnt    = acc_q;
    assign state_dbg  = state_q;

    // State and output registers; reset wins over everything, including a pending done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wl_q     <= 8'h00;
            pre_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            acc_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wl_q     <= wl_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            acc_q    <= acc_d;
        end
    end

    // Next-state and next-output decode; outputs are computed one cycle ahead so they leave registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wl_d     = wl_q;
        pre_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        acc_d    = acc_q;
        sticky_d = sticky_q;

        // A clear is overridden below if an illegal word lands in the same cycle.
        if (err_clr) begin
            sticky_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                wl_d = 8'h00;
                if (accept) begin
                    if (word_legal) begin
                        state_d = ACTIVE;
                        wl_d    = word;
                        cnt_d   = PULSE_LD;
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = PRECH;
                    wl_d    = 8'h00;
                    pre_d   = 1'b1;
                    cnt_d   = PRE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            PRECH: begin
                wl_d = 8'h00;
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    acc_d   = acc_q + 16'h0001;
                end else begin
                    pre_d = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wl_d    = 8'h00;
                cnt_d   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_wl_pulse_ctrl.sv
// Bench for wl_pulse_ctrl with default parameters (PULSE_W=4, PRE_W=2).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_wl_pulse_ctrl;

    localparam int P = 4;
    localparam int R = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  word;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  wl_out;
    logic        pre_en;
    logic        done;
    logic        err;
    logic        err_sticky;
    logic        err_clr;
    logic [15:0] acc_cnt;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    wl_pulse_ctrl #(.PULSE_W(P), .PRE_W(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .word       (word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wl_out     (wl_out),
        .pre_en     (pre_en),
        .done       (done),
        .err        (err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .acc_cnt    (acc_cnt),
        .state_dbg  (state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  word;
        logic        clr;
        logic [7:0]  e_wl;
        logic        e_pre;
        logic        e_done;
        logic        e_err;
        logic        e_sticky;
        logic        e_rdy;
        logic [15:0] e_acc;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    function automatic vec_t mk(logic r, logic v, logic [7:0] w, logic c,
                                logic [7:0] ewl, logic ep, logic ed, logic ee,
                                logic es, logic er, logic [15:0] ea);
        vec_t t;
        t.rst = r; t.vld = v; t.word = w; t.clr = c;
        t.e_wl = ewl; t.e_pre = ep; t.e_done = ed; t.e_err = ee;
        t.e_sticky = es; t.e_rdy = er; t.e_acc = ea;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic v, logic [7:0] w, logic c);
        @(negedge clk);
        rst = r; in_valid = v; word = w; err_clr = c;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [7:0] dec_3to8(int a);
        logic [7:0] one;
        one = 8'h01;
        return one << a;
    endfunction

    // ---------------- test body ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; word = 8'h00; err_clr = 1'b0;

        // Reset state, observed while rst is still high, then on release.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_wl", 32'(wl_out), 32'h0);
        chk("rst_pre", 32'(pre_en), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_sticky", 32'(err_sticky), 32'h0);
        chk("rst_acc", 32'(acc_cnt), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'h0);
        chk("rst_ready_held", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready_release", 32'(in_ready), 32'h1);

        // Table: single access of 0x04, then reset, illegal words and err_clr.
        vt[0]  = mk(0, 1, 8'h04, 0, 8'h00, 0, 0, 0, 0, 1, 16'd0);
        vt[1]  = mk(0, 0, 8'h00, 0, 8'h04, 0, 0, 0, 0, 0, 16'd0);
        vt[2]  = mk(0, 0, 8'h00, 0, 8'h04, 0, 0, 0, 0, 0, 16'd0);
        vt[3]  = mk(0, 0, 8'h00, 0, 8'h04, 0, 0, 0, 0, 0, 16'd0);
        vt[4]  = mk(0, 0, 8'h00, 0, 8'h04, 0, 0, 0, 0, 0, 16'd0);
        vt[5]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 16'd0);
        vt[6]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 16'd0);
        vt[7]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 16'd1);
        vt[8]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 16'd1);
        vt[9]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 16'd1);
        vt[10] = mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 16'd0);
        vt[11] = mk(0, 1, 8'h03, 0, 8'h00, 0, 0, 1, 1, 1, 16'd0);
        vt[12] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 1, 16'd0);
        vt[13] = mk(0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 1, 1, 16'd0);
        vt[14] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 16'd0);
        vt[15] = mk(0, 1, 8'h81, 1, 8'h00, 0, 0, 0, 0, 1, 16'd0);
        vt[16] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 1, 16'd0);
        vt[17] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 16'd0);
        vt[18] = mk(0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 1, 1, 16'd0);
        vt[19] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 16'd0);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].rst, vt[i].vld, vt[i].word, vt[i].clr);
            chk($sformatf("tbl%0d_wl", i), 32'(wl_out), 32'(vt[i].e_wl));
            chk($sformatf("tbl%0d_pre", i), 32'(pre_en), 32'(vt[i].e_pre));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(vt[i].e_done));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(vt[i].e_err));
            chk($sformatf("tbl%0d_sticky", i), 32'(err_sticky), 32'(vt[i].e_sticky));
            chk($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(vt[i].e_rdy));
            chk($sformatf("tbl%0d_acc", i), 32'(acc_cnt), 32'(vt[i].e_acc));
        end

        // Back-to-back: 0x01 then 0x80 with in_valid held high.
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            logic [7:0]  e_wl;
            logic        e_pre;
            logic        e_done;
            logic [15:0] e_acc;
            drive(1'b0, (c < 14), (c == 0) ? 8'h01 : 8'h80, 1'b0);
            e_wl   = (c >= 1 && c <= P) ? 8'h01 :
                     (c >= P + R + 2 && c <= 2 * P + R + 1) ? 8'h80 : 8'h00;
            e_pre  = (c >= P + 1 && c <= P + R) ||
                     (c >= 2 * P + R + 2 && c <= 2 * P + 2 * R + 1);
            e_done = (c == P + R + 1) || (c == 2 * (P + R + 1));
            e_acc  = (c < 7) ? 16'd0 : (c < 14) ? 16'd1 : 16'd2;
            chk($sformatf("b2b%0d_wl", c), 32'(wl_out), 32'(e_wl));
            chk($sformatf("b2b%0d_pre", c), 32'(pre_en), 32'(e_pre));
            chk($sformatf("b2b%0d_done", c), 32'(done), 32'(e_done));
            chk($sformatf("b2b%0d_acc", c), 32'(acc_cnt), 32'(e_acc));
        end

        // Reset in the second ACTIVE cycle of a 0x10 access.
        do_reset();
        drive(1'b0, 1'b1, 8'h10, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_wl_c1", 32'(wl_out), 32'h10);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        chk("midrst_wl_c2", 32'(wl_out), 32'h10);
        chk("midrst_ready_in_rst", 32'(in_ready), 32'h0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_wl_after", 32'(wl_out), 32'h0);
        chk("midrst_ready_after", 32'(in_ready), 32'h1);
        chk("midrst_acc_after", 32'(acc_cnt), 32'h0);
        begin
            int done_seen;
            done_seen = 0;
            for (int c = 0; c < 10; c++) begin
                drive(1'b0, 1'b0, 8'h00, 1'b0);
                if (done === 1'b1) done_seen++;
            end
            chk("midrst_no_done", 32'(done_seen), 32'h0);
            chk("midrst_acc_end", 32'(acc_cnt), 32'h0);
        end

        // Input stability: word and in_valid churn during ACTIVE; err_clr pulses too.
        do_reset();
        drive(1'b0, 1'b1, 8'h02, 1'b0);
        for (int c = 1; c <= P; c++) begin
            drive(1'b0, (c % 2) == 1, 8'h40 ^ 8'(c), (c == 2));
            chk($sformatf("stab%0d_wl", c), 32'(wl_out), 32'h02);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("stab_prech_wl", 32'(wl_out), 32'h0);
        chk("stab_prech_pre", 32'(pre_en), 32'h1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("stab_done", 32'(done), 32'h1);
        chk("stab_acc", 32'(acc_cnt), 32'h1);

        // Sweep all decoder outputs; scoreboard matches each pulse to its word.
        do_reset();
        begin
            int         idx;
            int         overlap;
            int         rises [8];
            logic [7:0] prev_wl;
            logic [7:0] got;
            idx = 0; overlap = 0; prev_wl = 8'h00;
            for (int b = 0; b < 8; b++) rises[b] = 0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                #1;
                if (wl_out != 8'h00 && pre_en) overlap++;
                for (int b = 0; b < 8; b++)
                    if (wl_out[b] && !prev_wl[b]) rises[b]++;
                if (wl_out != 8'h00 && prev_wl == 8'h00) begin
                    if (exp_q.size() == 0) begin
                        chk("sweep_unexpected_pulse", 32'(wl_out), 32'h0);
                    end else begin
                        got = exp_q.pop_front();
                        chk($sformatf("sweep_word%0d", c), 32'(wl_out), 32'(got));
                    end
                end
                prev_wl = wl_out;
                if (in_ready && idx < 8) begin
                    in_valid = 1'b1;
                    word     = dec_3to8(idx);
                    exp_q.push_back(dec_3to8(idx));
                    idx++;
                end else begin
                    in_valid = 1'b0;
                    word     = 8'h00;
                end
            end
            chk("sweep_issued", 32'(idx), 32'd8);
            chk("sweep_queue_empty", 32'(exp_q.size()), 32'd0);
            chk("sweep_no_overlap", 32'(overlap), 32'd0);
            for (int b = 0; b < 8; b++)
                chk($sformatf("sweep_bit%0d_once", b), 32'(rises[b]), 32'd1);
            chk("sweep_acc", 32'(acc_cnt), 32'd8);
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wl_pulse_ctrl.md
WL_PULSE_CTRL -- requirements
Module: wl_pulse_ctrl

Interface
REQ-001 SHALL have parameter PULSE_W, default 4: word-line active cycles per access, legal range 1..16.
REQ-002 SHALL have parameter PRE_W, default 2: precharge cycles after each pulse, legal range 1..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port word, input, 8: one-hot word select from the upstream 3-to-8 decoder.
REQ-006 SHALL have port in_valid, input, 1: word is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts word this cycle.
REQ-008 SHALL have port wl_out, output, 8: registered word-line drive.
REQ-009 SHALL have port pre_en, output, 1: registered precharge enable.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when an access completes.
REQ-011 SHALL have port err, output, 1: one-cycle pulse when an illegal word is accepted.
REQ-012 SHALL have port err_sticky, output, 1: latched illegal-word flag.
REQ-013 SHALL have port err_clr, input, 1: clears err_sticky.
REQ-014 SHALL have port acc_cnt, output, 16: count of legal accesses completed.

Function
REQ-015 SHALL implement the states IDLE, ACTIVE and PRECH, with one down-counter sized for 16.
REQ-016 SHALL drive in_ready = 1 only in IDLE; in_ready SHALL be a combinational decode of the state, independent of in_valid.
REQ-017 SHALL accept a word only on a cycle with in_valid & in_ready.
REQ-018 SHALL classify an accepted word as legal only if exactly one bit is set; zero bits or two or more bits SHALL be illegal.
REQ-019 On a legal accept at edge T0, SHALL enter ACTIVE; wl_out SHALL equal the accepted word for exactly PULSE_W cycles, starting at the cycle after T0.
REQ-020 After ACTIVE, SHALL enter PRECH: wl_out = 0 and pre_en = 1 for exactly PRE_W cycles; wl_out and pre_en SHALL never both be nonzero in the same cycle.
REQ-021 After PRECH, SHALL return to IDLE; in that first IDLE cycle done = 1 and acc_cnt SHALL be incremented by 1.
REQ-022 acc_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-023 SHALL accept a new word in the same cycle that done = 1; back-to-back period SHALL be PULSE_W+PRE_W+1 cycles.
REQ-024 SHALL ignore word and in_valid while in ACTIVE or PRECH; the latched word SHALL not change mid-access.
REQ-025 On an illegal accept, SHALL remain in IDLE with wl_out = 0, pulse err for one cycle on the next cycle, and set err_sticky; acc_cnt and done SHALL be unchanged.
REQ-026 err_sticky SHALL clear on err_clr; if err_clr and a new illegal accept occur in the same cycle, the set SHALL win.
REQ-027 err_clr SHALL have no effect on the state, wl_out or acc_cnt.

Reset
REQ-028 On rst = 1 at a clock edge, the next cycle SHALL show state IDLE, wl_out = 0, pre_en = 0, done = 0, err = 0, err_sticky = 0 and acc_cnt = 0.
REQ-029 rst SHALL take priority over every other input, including mid-ACTIVE and mid-PRECH; any pending done SHALL be suppressed.
REQ-030 in_ready SHALL be 0 while rst = 1, and 1 in the first cycle after reset is released.

Verification
REQ-031 Bench SHALL cover a single access with defaults, word=8'b0000_0100 accepted at cycle 0 -> wl_out=0x04 in cycles 1-4; pre_en=1 in cycles 5-6; done=1, acc_cnt=1 and in_ready=1 at cycle 7.
REQ-032 Bench SHALL cover back-to-back accesses, 0x01 then 0x80 with in_valid held high -> second wl_out=0x80 starts at cycle 8; acc_cnt=2 at cycle 14.
REQ-033 Bench SHALL cover illegal words, 0x00 then 0x03 -> err pulses at cycles 1 and 2; err_sticky=1; wl_out stays 0; acc_cnt=0; an err_clr pulse clears err_sticky the next cycle.
REQ-034 Bench SHALL cover reset mid-access, with rst asserted in cycle 2 of ACTIVE for 0x10 -> next cycle wl_out=0, no done pulse, acc_cnt=0, in_ready=1 after release.
REQ-035 Bench SHALL cover input stability: word changes and in_valid toggles during ACTIVE -> wl_out holds the original word for all PULSE_W cycles.
REQ-036 Bench SHALL sweep all 8 one-hot words driven by dec_3to8 for a = 0..7 -> each wl_out bit pulses exactly once and acc_cnt=8.
